// File: rtl/tmr_pkg.sv
// -----------------------------------------------------------------------------
// tmr_pkg
// Shared definitions for the triple-redundant input filter:
//   - default filter length and mismatch persistence limit
//   - channel index constants (CH_A / CH_B / CH_C)
//   - clog2 counter-width helper and a 2-of-3 flag helper
// No ports (package).
// -----------------------------------------------------------------------------
package tmr_pkg;

  localparam int FILT_CYCLES_DEF    = 16;
  localparam int MISMATCH_LIMIT_DEF = 64;

  localparam int NUM_CH = 3;
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_C   = 2;

  // Number of bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

  // True when at least two of the three flags are set.
  function automatic logic at_least_two(input logic [2:0] flags);
    return (flags[0] & flags[1]) | (flags[0] & flags[2]) | (flags[1] & flags[2]);
  endfunction

endpackage : tmr_pkg

// File: rtl/tmr_chan_filter.sv
// -----------------------------------------------------------------------------
// tmr_chan_filter
// One redundant channel: 2-flop synchronizer followed by a stability filter.
// The output only changes after FILT_CYCLES consecutive synchronized samples
// that all differ from the current output.
// Ports:
//   sys_clk  in  1  clock, rising edge
//   sys_rst  in  1  synchronous active-high reset
//   in_raw   in  1  raw channel input, asynchronous to sys_clk
//   ch_out   out 1  filtered, registered channel level
// -----------------------------------------------------------------------------
module tmr_chan_filter
  import tmr_pkg::*;
#(
  parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic in_raw,
  output logic ch_out
);

  localparam int                CNT_W    = clog2(FILT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_out;
  logic [CNT_W-1:0] r_cnt;

  logic             w_differs;
  logic             w_expire;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_out_next;

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter: counts consecutive differing samples; the sample that
  // completes the run is taken directly, so FILT_CYCLES=1 gives one cycle delay.
  always_comb begin
    w_differs  = (r_sync2 != r_out);
    w_expire   = w_differs && (r_cnt == CNT_LAST);
    w_cnt_next = r_cnt;
    w_out_next = r_out;
    if (!w_differs) begin
      w_cnt_next = {CNT_W{1'b0}};
    end else if (w_expire) begin
      w_cnt_next = {CNT_W{1'b0}};
      w_out_next = r_sync2;
    end else begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  // Filter state registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt <= {CNT_W{1'b0}};
      r_out <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_out <= w_out_next;
    end
  end

  assign ch_out = r_out;

endmodule : tmr_chan_filter

// File: rtl/tmr_input_filter.sv
// -----------------------------------------------------------------------------
// tmr_input_filter
// Three redundant inputs are synchronized and debounced, then compared.
// A persistent disagreement attributed to the same minority channel for
// MISMATCH_LIMIT cycles latches a sticky fault bit for that channel.
// Ports:
//   sys_clk      in  1  clock, rising edge
//   sys_rst      in  1  synchronous active-high reset
//   in_a/b/c     in  1  raw redundant inputs (asynchronous)
//   clear_fault  in  1  one-cycle request to clear the sticky fault flags
//   ch_a/b/c     out 1  filtered channel levels for the downstream voter
//   mismatch     out 1  registered: filtered channels not all equal
//   fault        out 3  sticky fault flags, bit0=a bit1=b bit2=c
//   degraded     out 1  registered: two or more fault flags set
// -----------------------------------------------------------------------------
module tmr_input_filter
  import tmr_pkg::*;
#(
  parameter int FILT_CYCLES    = FILT_CYCLES_DEF,
  parameter int MISMATCH_LIMIT = MISMATCH_LIMIT_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       in_a,
  input  logic       in_b,
  input  logic       in_c,
  input  logic       clear_fault,
  output logic       ch_a,
  output logic       ch_b,
  output logic       ch_c,
  output logic       mismatch,
  output logic [2:0] fault,
  output logic       degraded
);

  localparam int               MM_W     = clog2(MISMATCH_LIMIT + 1);
  localparam logic [MM_W-1:0]  MM_LIMIT = MM_W'(MISMATCH_LIMIT);

  logic [2:0]      w_ch;
  logic            w_disagree;
  logic [1:0]      w_minority;
  logic            w_min_changed;
  logic [1:0]      w_minority_next;
  logic [MM_W-1:0] w_mm_cnt_next;
  logic [2:0]      w_fault_set;
  logic [2:0]      w_fault_next;

  logic [1:0]      r_minority;
  logic [MM_W-1:0] r_mm_cnt;
  logic            r_mismatch;
  logic [2:0]      r_fault;
  logic            r_degraded;

  tmr_chan_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in_raw  (in_a),
    .ch_out  (w_ch[CH_A])
  );

  tmr_chan_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in_raw  (in_b),
    .ch_out  (w_ch[CH_B])
  );

  tmr_chan_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt_c (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in_raw  (in_c),
    .ch_out  (w_ch[CH_C])
  );

  // Disagreement detect and odd-one-out decode (only meaningful on disagreement).
  always_comb begin
    w_disagree = !((w_ch[CH_A] == w_ch[CH_B]) && (w_ch[CH_B] == w_ch[CH_C]));
    if (w_ch[CH_A] == w_ch[CH_B]) begin
      w_minority = 2'(CH_C);
    end else if (w_ch[CH_A] == w_ch[CH_C]) begin
      w_minority = 2'(CH_B);
    end else begin
      w_minority = 2'(CH_A);
    end
  end

  // Mismatch persistence counter and fault set/clear. A fault is raised only on
  // the edge the count first arrives at the limit (or re-arrives after a
  // minority change), so a saturated count cannot re-set a just-cleared flag.
  always_comb begin
    w_min_changed   = (w_minority != r_minority);
    w_minority_next = r_minority;
    w_mm_cnt_next   = r_mm_cnt;
    w_fault_set     = 3'b000;
    if (!w_disagree) begin
      w_mm_cnt_next = {MM_W{1'b0}};
    end else begin
      w_minority_next = w_minority;
      if (w_min_changed) begin
        w_mm_cnt_next = MM_W'(1);
      end else if (r_mm_cnt == MM_LIMIT) begin
        w_mm_cnt_next = r_mm_cnt;
      end else begin
        w_mm_cnt_next = r_mm_cnt + MM_W'(1);
      end
      if ((w_mm_cnt_next == MM_LIMIT) && (w_min_changed || (r_mm_cnt != MM_LIMIT))) begin
        w_fault_set = 3'b001 << w_minority;
      end else begin
        w_fault_set = 3'b000;
      end
    end
    // A coincident set wins over the clear for its own bit.
    w_fault_next = (clear_fault ? 3'b000 : r_fault) | w_fault_set;
  end

  // Comparison, fault and status registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_minority <= 2'b00;
      r_mm_cnt   <= {MM_W{1'b0}};
      r_mismatch <= 1'b0;
      r_fault    <= 3'b000;
      r_degraded <= 1'b0;
    end else begin
      r_minority <= w_minority_next;
      r_mm_cnt   <= w_mm_cnt_next;
      r_mismatch <= w_disagree;
      r_fault    <= w_fault_next;
      r_degraded <= at_least_two(r_fault);
    end
  end

  assign ch_a     = w_ch[CH_A];
  assign ch_b     = w_ch[CH_B];
  assign ch_c     = w_ch[CH_C];
  assign mismatch = r_mismatch;
  assign fault    = r_fault;
  assign degraded = r_degraded;

endmodule : tmr_input_filter
